hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stall, redirect flush, memory freeze, HALT drain.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  idRs,
  input  logic [2:0]  idRt,
  input  logic        idUsesRs,
  input  logic        idUsesRt,
  input  logic        idValid,
  input  logic        idHalt,
  input  logic [2:0]  exWritereg,
  input  logic        exRegWrite,
  input  logic        exMemRead,
  input  logic        exRedirect,
  input  logic        memBusy,
  output logic        pcWrite,
  output logic        ifidWrite,
  output logic        idexWrite,
  output logic        ifidFlush,
  output logic        idexBubble,
  output logic        halted,
  output logic [15:0] stallCycles,
  output logic [15:0] flushCount
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  state_e     state_q, state_d;
  logic [1:0] drain_cnt_q, drain_cnt_d;
  logic       load_use;

  assign load_use = idValid & exMemRead & exRegWrite &
                    ((idUsesRs & (idRs == exWritereg)) |
                     (idUsesRt & (idRt == exWritereg)));

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pcWrite     = 1'b0;
    ifidWrite   = 1'b0;
    idexWrite   = 1'b0;
    ifidFlush   = 1'b0;
    idexBubble  = 1'b0;
    halted      = 1'b0;
    if (state_q == HALTED) begin
      halted = 1'b1;
    end else if (memBusy) begin
      state_d = state_q;
    end else if (state_q == DRAIN) begin
      ifidWrite   = 1'b1;
      idexWrite   = 1'b1;
      ifidFlush   = 1'b1;
      idexBubble  = 1'b1;
      drain_cnt_d = drain_cnt_q - 2'd1;
      if (drain_cnt_q == 2'd0) state_d = HALTED;
    end else begin
      pcWrite   = 1'b1;
      ifidWrite = 1'b1;
      idexWrite = 1'b1;
      if (exRedirect) begin
        ifidFlush  = 1'b1;
        idexBubble = 1'b1;
      end else if (load_use) begin
        // the bubble inserted now removes the match next cycle
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        idexBubble = 1'b1;
      end else if (idValid & idHalt) begin
        state_d     = DRAIN;
        drain_cnt_d = 2'd3;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      drain_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        stall_ev, flush_ev;

  // only a load-use stall bubbles without flushing; only a redirect flushes with pcWrite
  assign stall_ev = (memBusy & ~halted) | (idexBubble & ~ifidFlush);
  assign flush_ev = ifidFlush & pcWrite;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush_ev && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCycles = stall_cnt_q;
  assign flushCount  = flush_cnt_q;
`else
  assign stallCycles = 16'd0;
  assign flushCount  = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  // {pcWrite, ifidWrite, idexWrite, ifidFlush, idexBubble, halted}
  localparam logic [5:0] RUN_OK = 6'b111000;
  localparam logic [5:0] STALL  = 6'b001010;
  localparam logic [5:0] FLUSH  = 6'b111110;
  localparam logic [5:0] FREEZE = 6'b000000;
  localparam logic [5:0] DRAIN  = 6'b011110;
  localparam logic [5:0] HALT   = 6'b000001;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  idRs, idRt, exWritereg;
  logic        idUsesRs, idUsesRt, idValid, idHalt;
  logic        exRegWrite, exMemRead, exRedirect, memBusy;
  logic        pcWrite, ifidWrite, idexWrite, ifidFlush, idexBubble, halted;
  logic [15:0] stallCycles, flushCount;
  logic [5:0]  outs;

  int errors = 0;
  int checks = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .idRs(idRs), .idRt(idRt),
    .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
    .idValid(idValid), .idHalt(idHalt),
    .exWritereg(exWritereg),
    .exRegWrite(exRegWrite), .exMemRead(exMemRead),
    .exRedirect(exRedirect), .memBusy(memBusy),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexWrite(idexWrite),
    .ifidFlush(ifidFlush), .idexBubble(idexBubble), .halted(halted),
    .stallCycles(stallCycles), .flushCount(flushCount)
  );

  always #5 clk = ~clk;

  assign outs = {pcWrite, ifidWrite, idexWrite, ifidFlush, idexBubble, halted};

  task automatic clr();
    idRs = 3'd0; idRt = 3'd0; exWritereg = 3'd0;
    idUsesRs = 1'b0; idUsesRt = 1'b0; idValid = 1'b0; idHalt = 1'b0;
    exRegWrite = 1'b0; exMemRead = 1'b0; exRedirect = 1'b0; memBusy = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_load_r3();
    exMemRead = 1'b1; exRegWrite = 1'b1; exWritereg = 3'd3;
    idValid = 1'b1; idRs = 3'd3; idUsesRs = 1'b1;
  endtask

  task automatic test_reset();
    clr();
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== RUN_OK) begin
      errors++; $display("FAIL rst_outs: got %b want %b", outs, RUN_OK);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== RUN_OK) begin
      errors++; $display("FAIL rst_idle: got %b want %b", outs, RUN_OK);
    end
    checks++;
    if (stallCycles !== 16'd0 || flushCount !== 16'd0) begin
      errors++;
      $display("FAIL rst_cnt: got %0d/%0d want 0/0", stallCycles, flushCount);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_r3();
    #1;
    checks++;
    if (outs !== STALL) begin
      errors++; $display("FAIL lu_stall: got %b want %b", outs, STALL);
    end
    cyc();
    exMemRead = 1'b0; exRegWrite = 1'b0;
    #1;
    checks++;
    if (outs !== RUN_OK) begin
      errors++; $display("FAIL lu_after: got %b want %b", outs, RUN_OK);
    end
    checks++;
    if (stallCycles !== 16'(PERF)) begin
      errors++; $display("FAIL lu_cnt: got %0d want %0d", stallCycles, PERF);
    end
  endtask

  task automatic test_redirect_priority();
    do_reset();
    set_load_r3();
    idHalt = 1'b1;
    exRedirect = 1'b1;
    #1;
    checks++;
    if (outs !== FLUSH) begin
      errors++; $display("FAIL rd_flush: got %b want %b", outs, FLUSH);
    end
    cyc();
    clr();
    #1;
    checks++;
    if (outs !== RUN_OK) begin
      errors++; $display("FAIL rd_nohalt: got %b want %b", outs, RUN_OK);
    end
    checks++;
    if (flushCount !== 16'(PERF) || stallCycles !== 16'd0) begin
      errors++;
      $display("FAIL rd_cnt: got %0d/%0d want %0d/0", flushCount, stallCycles, PERF);
    end
  endtask

  task automatic test_membusy();
    do_reset();
    set_load_r3();
    memBusy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (outs !== FREEZE) begin
        errors++; $display("FAIL mb_freeze%0d: got %b want %b", i, outs, FREEZE);
      end
      cyc();
    end
    memBusy = 1'b0;
    #1;
    checks++;
    if (outs !== STALL) begin
      errors++; $display("FAIL mb_stall: got %b want %b", outs, STALL);
    end
    cyc();
    clr();
    #1;
    checks++;
    if (outs !== RUN_OK) begin
      errors++; $display("FAIL mb_after: got %b want %b", outs, RUN_OK);
    end
    checks++;
    if (stallCycles !== 16'(5 * PERF)) begin
      errors++; $display("FAIL mb_cnt: got %0d want %0d", stallCycles, 5 * PERF);
    end
  endtask

  task automatic test_r0();
    do_reset();
    exMemRead = 1'b1; exRegWrite = 1'b1; exWritereg = 3'd0;
    idValid = 1'b1; idRs = 3'd0; idRt = 3'd0;
    #1;
    checks++;
    if (outs !== RUN_OK) begin
      errors++; $display("FAIL r0_unused: got %b want %b", outs, RUN_OK);
    end
    idUsesRt = 1'b1;
    #1;
    checks++;
    if (outs !== STALL) begin
      errors++; $display("FAIL r0_rt: got %b want %b", outs, STALL);
    end
    idValid = 1'b0;
    #1;
    checks++;
    if (outs !== RUN_OK) begin
      errors++; $display("FAIL r0_invalid: got %b want %b", outs, RUN_OK);
    end
    idValid = 1'b1; idRt = 3'd5;
    #1;
    checks++;
    if (outs !== RUN_OK) begin
      errors++; $display("FAIL r0_nomatch: got %b want %b", outs, RUN_OK);
    end
  endtask

  task automatic test_halt();
    do_reset();
    idValid = 1'b1; idHalt = 1'b1;
    #1;
    checks++;
    if (outs !== RUN_OK) begin
      errors++; $display("FAIL ht_adv: got %b want %b", outs, RUN_OK);
    end
    cyc();
    clr();
    exRedirect = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (outs !== DRAIN) begin
        errors++; $display("FAIL ht_drain%0d: got %b want %b", i, outs, DRAIN);
      end
      cyc();
    end
    clr();
    for (int i = 0; i < 3; i++) begin
      memBusy = (i == 1);
      #1;
      checks++;
      if (outs !== HALT) begin
        errors++; $display("FAIL ht_halted%0d: got %b want %b", i, outs, HALT);
      end
      cyc();
    end
    checks++;
    if (stallCycles !== 16'd0 || flushCount !== 16'd0) begin
      errors++;
      $display("FAIL ht_cnt: got %0d/%0d want 0/0", stallCycles, flushCount);
    end
  endtask

  task automatic test_halt_behind_stall();
    do_reset();
    set_load_r3();
    idHalt = 1'b1;
    #1;
    checks++;
    if (outs !== STALL) begin
      errors++; $display("FAIL hs_stall: got %b want %b", outs, STALL);
    end
    cyc();
    exMemRead = 1'b0; exRegWrite = 1'b0;
    #1;
    checks++;
    if (outs !== RUN_OK) begin
      errors++; $display("FAIL hs_adv: got %b want %b", outs, RUN_OK);
    end
    cyc();
    clr();
    #1;
    checks++;
    if (outs !== DRAIN) begin
      errors++; $display("FAIL hs_drain: got %b want %b", outs, DRAIN);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_load_r3();
    cyc();
    clr();
    idValid = 1'b1; idHalt = 1'b1;
    cyc();
    clr();
    cyc();
    checks++;
    if (outs !== DRAIN) begin
      errors++; $display("FAIL ar_pre: got %b want %b", outs, DRAIN);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (outs !== RUN_OK) begin
      errors++; $display("FAIL ar_async: got %b want %b", outs, RUN_OK);
    end
    checks++;
    if (stallCycles !== 16'd0) begin
      errors++; $display("FAIL ar_cnt: got %0d want 0", stallCycles);
    end
    #1 rst = 1'b0;
    cyc();
    #1;
    checks++;
    if (outs !== RUN_OK) begin
      errors++; $display("FAIL ar_run: got %b want %b", outs, RUN_OK);
    end
  endtask

  initial begin
    clr();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_redirect_priority();
    test_membusy();
    test_r0();
    test_halt();
    test_halt_behind_stall();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
